alu_slice_cmp: RTL and testbench

- Parametrised, multi-cycle successor to the cpu6502 ALU compare path.
- Performs ADC, SBC, CMP or BIT on WIDTH-bit operands, SLICE bits per clock, LSB slice first.
- Produces 6502-layout flags: N=7, V=6, Z=1, C=0. All other flag bits pass through unchanged from flags_in.
- Sits beside control0. Lets wide, 16-bit extended cores share one narrow adder; a start/busy/done handshake replaces the single-cycle ALU.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_slice_add.sv | 18 +
 rtl/alu_slice_cmp.sv | 169 ++++++++++++++++
 tb/tb_alu_slice_cmp.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sliced ADC/SBC/CMP/BIT unit: opcodes, 6502 flag positions, FSM states.
// Pure declarations, no timing; backpressure n/a.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADC = 2'b00,
        OP_SBC = 2'b01,
        OP_CMP = 2'b10,
        OP_BIT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int FLAG_N = 7;
    localparam int FLAG_V = 6;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    // Subtract-style ops feed the adder with the ones' complement of b.
    function automatic logic invert_b(input op_e op);
        return (op == OP_SBC) || (op == OP_CMP);
    endfunction

    // CMP always subtracts with borrow clear, ignoring the incoming carry flag.
    function automatic logic initial_carry(input op_e op, input logic flag_c);
        return (op == OP_CMP) ? 1'b1 : flag_c;
    endfunction

endpackage

// File: rtl/alu_slice_add.sv
// Combinational SLICE-bit adder with carry in and carry out.
// Latency 0; no backpressure.
module alu_slice_add #(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_sum,
    output logic             o_cout
);

    logic [SLICE:0] w_full;

    assign w_full          = {1'b0, i_a} + {1'b0, i_b} + {{SLICE{1'b0}}, i_cin};
    assign {o_cout, o_sum} = w_full;

endmodule

// File: rtl/alu_slice_cmp.sv
// Multi-cycle ADC/SBC/CMP/BIT unit sharing one SLICE-bit adder, LSB slice first, 6502 flag layout.
// Latency: done pulses WIDTH/SLICE cycles after the start edge; start while busy is ignored.
module alu_slice_cmp
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [7:0]       i_flags_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_wr_en,
    output logic [7:0]       o_flags_out
);

    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_acc_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [1:0]       r_bmsb;
    logic [7:0]       r_flags;
    logic             r_carry;
    logic             r_zor;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_wr_en;
    logic [WIDTH-1:0] r_result;
    logic [7:0]       r_flags_out;

    op_e              w_op_in;
    logic [WIDTH-1:0] w_bx_in;
    logic             w_is_bit;
    logic             w_is_arith;
    logic [SLICE-1:0] w_add_sum;
    logic             w_add_cout;
    logic [SLICE-1:0] w_slice;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_zero;
    logic             w_last;
    logic [7:0]       w_flags_next;
    logic [WIDTH-1:0] w_result_next;

    assign w_op_in    = op_e'(i_op);
    assign w_bx_in    = invert_b(w_op_in) ? ~i_b : i_b;
    assign w_is_bit   = (r_op == OP_BIT);
    assign w_is_arith = (r_op == OP_ADC) || (r_op == OP_SBC);

    alu_slice_add #(.SLICE(SLICE)) u_add (
        .i_a    (r_acc_sh[SLICE-1:0]),
        .i_b    (r_b_sh[SLICE-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    assign w_slice = w_is_bit ? (r_acc_sh[SLICE-1:0] & r_b_sh[SLICE-1:0]) : w_add_sum;

    // a is consumed from the bottom of r_acc_sh while sum slices enter at the top,
    // so after NS shifts the register holds the aligned result.
    generate
        if (NS > 1) begin : g_multi
            assign w_sum_next = {w_slice, r_acc_sh[WIDTH-1:SLICE]};
        end else begin : g_single
            assign w_sum_next = w_slice;
        end
    endgenerate

    assign w_zero        = ~(r_zor | (|w_slice));
    assign w_last        = (r_cnt == CW'(NS - 1));
    assign w_result_next = w_is_arith ? w_sum_next : r_a;

    always_comb begin
        w_flags_next = r_flags;
        if (w_is_bit) begin
            w_flags_next[FLAG_N] = r_bmsb[1];
            w_flags_next[FLAG_V] = r_bmsb[0];
            w_flags_next[FLAG_Z] = w_zero;
        end else begin
            w_flags_next[FLAG_N] = w_sum_next[WIDTH-1];
            w_flags_next[FLAG_Z] = w_zero;
            w_flags_next[FLAG_C] = w_add_cout;
            if (w_is_arith) begin
                w_flags_next[FLAG_V] = (r_a[WIDTH-1] == r_bmsb[1]) &&
                                       (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_op        <= OP_ADC;
            r_a         <= '0;
            r_acc_sh    <= '0;
            r_b_sh      <= '0;
            r_bmsb      <= '0;
            r_flags     <= '0;
            r_carry     <= 1'b0;
            r_zor       <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_result    <= '0;
            r_flags_out <= '0;
        end else begin
            r_done  <= 1'b0;
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_state  <= RUN;
                        r_busy   <= 1'b1;
                        r_op     <= w_op_in;
                        r_a      <= i_a;
                        r_acc_sh <= i_a;
                        r_b_sh   <= w_bx_in;
                        r_bmsb   <= w_bx_in[WIDTH-1 -: 2];
                        r_flags  <= i_flags_in;
                        r_carry  <= initial_carry(w_op_in, i_flags_in[FLAG_C]);
                        r_zor    <= 1'b0;
                        r_cnt    <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc_sh <= w_sum_next;
                    r_b_sh   <= r_b_sh >> SLICE;
                    r_carry  <= w_add_cout;
                    r_zor    <= r_zor | (|w_slice);
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_wr_en     <= w_is_arith;
                        r_result    <= w_result_next;
                        r_flags_out <= w_flags_next;
                        r_cnt       <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_wr_en     = r_wr_en;
    assign o_result    = r_result;
    assign o_flags_out = r_flags_out;

endmodule

// File: tb/tb_alu_slice_cmp.sv
// Directed bench for alu_slice_cmp: 8-bit/2-bit-slice and 16-bit/4-bit-slice instances on one clock.
module tb_alu_slice_cmp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       s8_start,  s16_start;
    logic [1:0] s8_op,     s16_op;
    logic [7:0] s8_a, s8_b, s8_f;
    logic [15:0] s16_a, s16_b;
    logic [7:0] s16_f;

    logic       o8_busy, o8_done, o8_wr;
    logic [7:0] o8_res, o8_flags;
    logic       o16_busy, o16_done, o16_wr;
    logic [15:0] o16_res;
    logic [7:0] o16_flags;

    int checks   = 0;
    int failures = 0;

    alu_slice_cmp #(.WIDTH(8), .SLICE(2)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s8_start), .i_op(s8_op),
        .i_a(s8_a), .i_b(s8_b), .i_flags_in(s8_f),
        .o_busy(o8_busy), .o_done(o8_done), .o_result(o8_res),
        .o_wr_en(o8_wr), .o_flags_out(o8_flags)
    );

    alu_slice_cmp #(.WIDTH(16), .SLICE(4)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s16_start), .i_op(s16_op),
        .i_a(s16_a), .i_b(s16_b), .i_flags_in(s16_f),
        .o_busy(o16_busy), .o_done(o16_done), .o_result(o16_res),
        .o_wr_en(o16_wr), .o_flags_out(o16_flags)
    );

    localparam logic [1:0] ADC = 2'b00, SBC = 2'b01, CMP = 2'b10, BIT = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  fin;
        logic [15:0] exp_res;
        logic [7:0]  exp_flags;
        logic        exp_wr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic start, input logic [1:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic [7:0] f);
        if (sel == 0) begin
            s8_start = start; s8_op = op; s8_a = a[7:0]; s8_b = b[7:0]; s8_f = f;
        end else begin
            s16_start = start; s16_op = op; s16_a = a; s16_b = b; s16_f = f;
        end
    endtask

    task automatic sample(input int sel, output logic busy, output logic done, output logic wr,
                          output logic [15:0] res, output logic [7:0] fl);
        if (sel == 0) begin
            busy = o8_busy; done = o8_done; wr = o8_wr; res = {8'h00, o8_res}; fl = o8_flags;
        end else begin
            busy = o16_busy; done = o16_done; wr = o16_wr; res = o16_res; fl = o16_flags;
        end
    endtask

    // Presents a one-cycle start; returns 1 ns after the accepting edge.
    task automatic issue(input int sel, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] f, input string name);
        logic busy, done, wr;
        logic [15:0] res;
        logic [7:0] fl;
        @(negedge clk);
        drive(sel, 1'b1, op, a, b, f);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, op, a, b, f);
        sample(sel, busy, done, wr, res, fl);
        chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    // Counts edges until done; outputs must hold their previous values meanwhile.
    task automatic wait_done(input int sel, input logic [15:0] prev_res, input logic [7:0] prev_fl,
                             input string name, output int lat);
        logic busy, done, wr;
        logic [15:0] res;
        logic [7:0] fl;
        logic glitch;
        int i;
        lat = 0;
        glitch = 1'b0;
        i = 0;
        while (lat == 0 && i < 16) begin
            i++;
            @(posedge clk);
            #1;
            sample(sel, busy, done, wr, res, fl);
            if (done) lat = i;
            else if (res !== prev_res || fl !== prev_fl || wr !== 1'b0) glitch = 1'b1;
        end
        chk({name, "_hold"}, {31'd0, glitch}, 32'd0);
    endtask

    task automatic check_result(input int sel, input string name, input vec_t v);
        logic busy, done, wr;
        logic [15:0] res;
        logic [7:0] fl;
        sample(sel, busy, done, wr, res, fl);
        chk({name, "_result"}, {16'd0, res}, {16'd0, v.exp_res});
        chk({name, "_flags"},  {24'd0, fl},  {24'd0, v.exp_flags});
        chk({name, "_wr_en"},  {31'd0, wr},  {31'd0, v.exp_wr});
        chk({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v8[10];
        vec_t v16[2];
        vec_t v;
        logic busy, done, wr;
        logic [15:0] res, pres;
        logic [7:0] fl, pfl;
        logic seen;
        int lat;

        v8[0] = '{CMP, 16'h02, 16'h01, 8'h00, 16'h02, 8'h01, 1'b0};
        v8[1] = '{CMP, 16'h40, 16'h40, 8'h00, 16'h40, 8'h03, 1'b0};
        v8[2] = '{CMP, 16'h01, 16'h02, 8'h00, 16'h01, 8'h80, 1'b0};
        v8[3] = '{ADC, 16'h7F, 16'h01, 8'h00, 16'h80, 8'hC0, 1'b1};
        v8[4] = '{SBC, 16'h00, 16'h01, 8'h01, 16'hFF, 8'h80, 1'b1};
        v8[5] = '{BIT, 16'h0F, 16'hC0, 8'h24, 16'h0F, 8'hE6, 1'b0};
        v8[6] = '{ADC, 16'hFF, 16'h01, 8'h3C, 16'h00, 8'h3F, 1'b1};
        v8[7] = '{SBC, 16'h80, 16'h01, 8'h01, 16'h7F, 8'h41, 1'b1};
        v8[8] = '{CMP, 16'h05, 16'h05, 8'h40, 16'h05, 8'h43, 1'b0};
        v8[9] = '{BIT, 16'hFF, 16'h01, 8'hC3, 16'hFF, 8'h01, 1'b0};

        v16[0] = '{ADC, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h03, 1'b1};
        v16[1] = '{SBC, 16'h8000, 16'h0001, 8'h01, 16'h7FFF, 8'h41, 1'b1};

        rst_n = 1'b0;
        drive(0, 1'b0, ADC, 16'h0, 16'h0, 8'h00);
        drive(1, 1'b0, ADC, 16'h0, 16'h0, 8'h00);
        #12;
        for (int s = 0; s < 2; s++) begin
            sample(s, busy, done, wr, res, fl);
            chk($sformatf("reset%0d_busy", s), {31'd0, busy}, 32'd0);
            chk($sformatf("reset%0d_done", s), {31'd0, done}, 32'd0);
            chk($sformatf("reset%0d_wr", s), {31'd0, wr}, 32'd0);
            chk($sformatf("reset%0d_result", s), {16'd0, res}, 32'd0);
            chk($sformatf("reset%0d_flags", s), {24'd0, fl}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Each vector starts in the DONE cycle of the previous one: back-to-back acceptance.
        for (int i = 0; i < 10; i++) begin
            v = v8[i];
            sample(0, busy, done, wr, pres, pfl);
            issue(0, v.op, v.a, v.b, v.fin, $sformatf("v8_%0d", i));
            wait_done(0, pres, pfl, $sformatf("v8_%0d", i), lat);
            chk($sformatf("v8_%0d_latency", i), lat, 32'd4);
            check_result(0, $sformatf("v8_%0d", i), v);
        end

        @(posedge clk);
        #1;
        sample(0, busy, done, wr, res, fl);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("wr_one_cycle", {31'd0, wr}, 32'd0);
        chk("flags_held", {24'd0, fl}, {24'd0, v8[9].exp_flags});

        issue(0, ADC, 16'h7F, 16'h01, 8'h00, "abort");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        sample(0, busy, done, wr, res, fl);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result", {16'd0, res}, 32'd0);
        chk("abort_flags", {24'd0, fl}, 32'd0);
        chk("abort_wr", {31'd0, wr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (o8_done || o8_busy) seen = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);

        issue(0, CMP, 16'h02, 16'h01, 8'h00, "ign");
        @(negedge clk);
        drive(0, 1'b1, ADC, 16'hFF, 16'hFF, 8'h01);
        @(posedge clk);
        #1;
        chk("ign_no_early_done", {31'd0, o8_done}, 32'd0);
        drive(0, 1'b0, ADC, 16'hFF, 16'hFF, 8'h01);
        wait_done(0, 16'h0000, 8'h00, "ign", lat);
        chk("ign_latency", lat, 32'd3);
        v = '{CMP, 16'h02, 16'h01, 8'h00, 16'h02, 8'h01, 1'b0};
        check_result(0, "ign", v);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (o8_done || o8_busy) seen = 1'b1;
        end
        chk("ign_no_second_op", {31'd0, seen}, 32'd0);

        for (int i = 0; i < 2; i++) begin
            v = v16[i];
            sample(1, busy, done, wr, pres, pfl);
            issue(1, v.op, v.a, v.b, v.fin, $sformatf("v16_%0d", i));
            wait_done(1, pres, pfl, $sformatf("v16_%0d", i), lat);
            chk($sformatf("v16_%0d_latency", i), lat, 32'd4);
            check_result(1, $sformatf("v16_%0d", i), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
